// File: rtl/eros_obi_addr_demux.sv
// Single-master OBI address demultiplexer with an in-order response guarantee, a built-in error
// responder for unmapped accesses and a saturating decode-error counter.
module eros_obi_addr_demux #(
  parameter int unsigned NumSlaves = 5,
  parameter int unsigned NumRules  = 5,
  parameter int unsigned MaxTrans  = 4,
  parameter logic [31:0] ErrRData  = 32'hBADACCE5
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  // Each rule packed as {idx[95:64], start_addr[63:32], end_addr[31:0]}, end exclusive.
  input  logic [NumRules-1:0][95:0]         addr_map_i,
  input  logic                              err_cnt_clr_i,
  input  logic                              req_i,
  output logic                              gnt_o,
  input  logic [31:0]                       addr_i,
  input  logic [31:0]                       wdata_i,
  input  logic                              we_i,
  input  logic [3:0]                        be_i,
  output logic                              rvalid_o,
  output logic                              err_o,
  output logic [31:0]                       rdata_o,
  output logic [NumSlaves-1:0]              slv_req_o,
  input  logic [NumSlaves-1:0]              slv_gnt_i,
  output logic [31:0]                       slv_addr_o,
  output logic [31:0]                       slv_wdata_o,
  output logic                              slv_we_o,
  output logic [3:0]                        slv_be_o,
  input  logic [NumSlaves-1:0]              slv_rvalid_i,
  input  logic [NumSlaves-1:0]              slv_err_i,
  input  logic [NumSlaves-1:0][31:0]        slv_rdata_i,
  output logic [3:0]                        outstanding_o,
  output logic [15:0]                       err_cnt_o
);

  localparam int unsigned     TgtW   = $clog2(NumSlaves + 1);
  localparam logic [TgtW-1:0] TgtErr = TgtW'(NumSlaves);

  logic [TgtW-1:0] w_tgt;
  logic [TgtW-1:0] r_last_tgt;
  logic [3:0]      r_cnt;
  logic [3:0]      w_cnt_d;
  logic            r_err_pend;
  logic [15:0]     r_err_cnt;
  logic            w_tgt_err;
  logic            w_issue;
  logic            w_accept;

  // Later rules override earlier ones, so the highest-numbered match wins.
  always_comb begin
    w_tgt = TgtErr;
    for (int unsigned r = 0; r < NumRules; r++) begin
      if ((addr_i >= addr_map_i[r][63:32]) && (addr_i < addr_map_i[r][31:0])) begin
        w_tgt = (addr_map_i[r][95:64] < NumSlaves) ? TgtW'(addr_map_i[r][95:64]) : TgtErr;
      end
    end
  end

  assign w_tgt_err = (w_tgt == TgtErr);
  // Only one target may have responses in flight, which keeps responses in order.
  assign w_issue   = (r_cnt < 4'(MaxTrans)) && ((r_cnt == 4'd0) || (w_tgt == r_last_tgt));

  always_comb begin
    slv_req_o = '0;
    gnt_o     = 1'b0;
    if (w_issue) begin
      if (w_tgt_err) begin
        gnt_o = req_i;
      end else begin
        for (int unsigned s = 0; s < NumSlaves; s++) begin
          if (w_tgt == TgtW'(s)) begin
            slv_req_o[s] = req_i;
            gnt_o        = slv_gnt_i[s];
          end
        end
      end
    end
  end

  assign w_accept    = req_i & gnt_o;
  assign slv_addr_o  = addr_i;
  assign slv_wdata_o = wdata_i;
  assign slv_we_o    = we_i;
  assign slv_be_o    = be_i;

  // The cnt mask drops stale slave responses, e.g. ones arriving after a reset.
  always_comb begin
    rvalid_o = 1'b0;
    err_o    = 1'b0;
    rdata_o  = '0;
    if (r_err_pend) begin
      rvalid_o = 1'b1;
      err_o    = 1'b1;
      rdata_o  = ErrRData;
    end else if (r_cnt != 4'd0) begin
      for (int unsigned s = 0; s < NumSlaves; s++) begin
        if (r_last_tgt == TgtW'(s)) begin
          rvalid_o = slv_rvalid_i[s];
          err_o    = slv_err_i[s];
          rdata_o  = slv_rdata_i[s];
        end
      end
    end
  end

  assign w_cnt_d = r_cnt + 4'(w_accept) - 4'(rvalid_o);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt      <= 4'd0;
      r_last_tgt <= '0;
      r_err_pend <= 1'b0;
      r_err_cnt  <= 16'd0;
    end else begin
      r_cnt      <= w_cnt_d;
      r_err_pend <= w_accept & w_tgt_err;
      if (w_accept) begin
        r_last_tgt <= w_tgt;
      end
      if (err_cnt_clr_i) begin
        r_err_cnt <= 16'd0;
      end else if (w_accept && w_tgt_err && (r_err_cnt != 16'hFFFF)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign outstanding_o = r_cnt;
  assign err_cnt_o     = r_err_cnt;

endmodule

// File: tb/tb_eros_obi_addr_demux.sv
// Randomized bench for eros_obi_addr_demux: a queue-based reference model of outstanding targets
// plus a simple in-order slave responder, with directed scenarios for the main corner cases.
module tb_eros_obi_addr_demux;

  localparam int unsigned NS   = 5;
  localparam int unsigned NR   = 5;
  localparam int unsigned MT   = 4;
  localparam logic [31:0] ERRD = 32'hBADACCE5;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic [NR-1:0][95:0]  addr_map_i;
  logic                 err_cnt_clr_i;
  logic                 req_i, gnt_o;
  logic [31:0]          addr_i, wdata_i;
  logic                 we_i;
  logic [3:0]           be_i;
  logic                 rvalid_o, err_o;
  logic [31:0]          rdata_o;
  logic [NS-1:0]        slv_req_o, slv_gnt_i;
  logic [31:0]          slv_addr_o, slv_wdata_o;
  logic                 slv_we_o;
  logic [3:0]           slv_be_o;
  logic [NS-1:0]        slv_rvalid_i, slv_err_i;
  logic [NS-1:0][31:0]  slv_rdata_i;
  logic [3:0]           outstanding_o;
  logic [15:0]          err_cnt_o;

  eros_obi_addr_demux #(
    .NumSlaves(NS), .NumRules(NR), .MaxTrans(MT), .ErrRData(ERRD)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .addr_map_i(addr_map_i), .err_cnt_clr_i(err_cnt_clr_i),
    .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .wdata_i(wdata_i), .we_i(we_i),
    .be_i(be_i), .rvalid_o(rvalid_o), .err_o(err_o), .rdata_o(rdata_o),
    .slv_req_o(slv_req_o), .slv_gnt_i(slv_gnt_i), .slv_addr_o(slv_addr_o),
    .slv_wdata_o(slv_wdata_o), .slv_we_o(slv_we_o), .slv_be_o(slv_be_o),
    .slv_rvalid_i(slv_rvalid_i), .slv_err_i(slv_err_i), .slv_rdata_i(slv_rdata_i),
    .outstanding_o(outstanding_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  logic [31:0] map_idx [NR];
  logic [31:0] map_st  [NR];
  logic [31:0] map_en  [NR];

  always_comb begin
    for (int r = 0; r < NR; r++) addr_map_i[r] = {map_idx[r], map_st[r], map_en[r]};
  end

  typedef struct packed {
    int          slv;
    int          due;
    logic [31:0] data;
    logic        err;
  } bfm_t;

  int          n_cmp = 0;
  int          n_mis = 0;
  int          cyc   = 0;
  int          mq[$];          // targets of outstanding transactions, oldest first
  bfm_t        bfm_q[$];       // slave-side responses still to be returned
  logic [15:0] err_cnt_m;
  // master and slave-side knobs
  logic        m_req, m_we, m_clr, m_acc;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  int          gnt_pct, spur_pct, dmin, dmax;
  logic        hold, use_fixed;
  logic [31:0] fixed_rdata;
  // DUT outputs as seen in the last checked cycle
  logic        s_gnt, s_rvalid, s_err;
  logic [NS-1:0] s_slv_req;
  logic [31:0] s_rdata;
  logic [3:0]  s_outst;
  logic [15:0] s_errcnt;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int ref_decode(input logic [31:0] a);
    int t = NS;
    for (int r = 0; r < NR; r++) begin
      if (a >= map_st[r] && a < map_en[r]) t = (map_idx[r] < NS) ? int'(map_idx[r]) : NS;
    end
    return t;
  endfunction

  function automatic logic [31:0] rand_addr();
    int k = $urandom_range(0, 7);
    if (k < 5) return map_st[k] + $urandom_range(0, map_en[k] - map_st[k] - 1);
    if (k == 5) return 32'h3000_0000 + ($urandom_range(0, 255) << 2);
    if (k == 6) return 32'h1902_8000;
    return $urandom;
  endfunction

  task automatic set_default_map();
    map_idx[0] = 0; map_st[0] = 32'h0000_0000; map_en[0] = 32'h0001_0000;
    map_idx[1] = 1; map_st[1] = 32'h1900_0000; map_en[1] = 32'h1903_0000;
    map_idx[2] = 2; map_st[2] = 32'h1A00_0000; map_en[2] = 32'h1A01_0000;
    map_idx[3] = 3; map_st[3] = 32'h1902_0000; map_en[3] = 32'h1902_1000;
    map_idx[4] = 4; map_st[4] = 32'h1902_8000; map_en[4] = 32'h1902_9000;
  endtask

  // One clock cycle: drive at negedge, check 1 time unit later, advance the model at posedge.
  task automatic step();
    int          t, front, head;
    logic        ok, e_gnt, e_rv, e_err, drv, acc;
    logic [NS-1:0] e_req;
    logic [31:0] e_rd;
    @(negedge clk_i);
    req_i = m_req; addr_i = m_addr; wdata_i = m_wdata; we_i = m_we; be_i = m_be;
    err_cnt_clr_i = m_clr;
    for (int s = 0; s < NS; s++) begin
      slv_gnt_i[s]    = ($urandom_range(0, 99) < gnt_pct);
      slv_rdata_i[s]  = $urandom;
      slv_err_i[s]    = $urandom_range(0, 1);
      slv_rvalid_i[s] = 1'b0;
    end
    head = -1;
    drv  = 1'b0;
    if (bfm_q.size() > 0) begin
      head = bfm_q[0].slv;
      if (!hold && bfm_q[0].due <= cyc) begin
        drv = 1'b1;
        slv_rvalid_i[head] = 1'b1;
        slv_rdata_i[head]  = bfm_q[0].data;
        slv_err_i[head]    = bfm_q[0].err;
      end
    end
    front = (mq.size() > 0) ? mq[0] : -1;
    for (int s = 0; s < NS; s++) begin
      if (s != head && s != front && $urandom_range(0, 99) < spur_pct) slv_rvalid_i[s] = 1'b1;
    end
    #1;
    t  = ref_decode(m_addr);
    ok = (mq.size() < MT) && (mq.size() == 0 || mq[$] == t);
    e_req = '0;
    e_gnt = 1'b0;
    if (ok) begin
      if (t == NS) e_gnt = m_req;
      else begin
        e_req[t] = m_req;
        e_gnt    = slv_gnt_i[t];
      end
    end
    e_rv = 1'b0; e_err = 1'b0; e_rd = '0;
    if (mq.size() > 0) begin
      if (mq[0] == NS) begin
        e_rv = 1'b1; e_err = 1'b1; e_rd = ERRD;
      end else begin
        e_rv = slv_rvalid_i[mq[0]]; e_err = slv_err_i[mq[0]]; e_rd = slv_rdata_i[mq[0]];
      end
    end
    check_eq("gnt", gnt_o, e_gnt);
    check_eq("slv_req", slv_req_o, e_req);
    check_eq("rvalid", rvalid_o, e_rv);
    if (e_rv || mq.size() == 0) begin
      check_eq("rdata", rdata_o, e_rd);
      check_eq("err", err_o, e_err);
    end
    check_eq("outstanding", outstanding_o, mq.size());
    check_eq("err_cnt", err_cnt_o, err_cnt_m);
    check_eq("bcast", {slv_addr_o, slv_wdata_o, slv_we_o, slv_be_o},
             {m_addr, m_wdata, m_we, m_be});
    s_gnt = gnt_o; s_slv_req = slv_req_o; s_rvalid = rvalid_o; s_err = err_o;
    s_rdata = rdata_o; s_outst = outstanding_o; s_errcnt = err_cnt_o;
    @(posedge clk_i);
    acc = 1'b0;
    if (rst_ni) begin
      acc = m_req & e_gnt;
      if (e_rv) void'(mq.pop_front());
      if (acc) mq.push_back(t);
      if (m_clr) err_cnt_m = 16'd0;
      else if (acc && t == NS && err_cnt_m != 16'hFFFF) err_cnt_m = err_cnt_m + 16'd1;
      if (acc && t != NS) begin
        bfm_q.push_back('{slv: t, due: cyc + $urandom_range(dmin, dmax),
                          data: use_fixed ? fixed_rdata : $urandom,
                          err: use_fixed ? 1'b0 : ($urandom_range(0, 9) == 0)});
      end
    end
    if (drv) void'(bfm_q.pop_front());
    cyc++;
    m_acc = acc;
  endtask

  task automatic drain(input string tag);
    m_req = 1'b0; m_clr = 1'b0; hold = 1'b0;
    for (int i = 0; i < 200 && (mq.size() > 0 || bfm_q.size() > 0); i++) step();
    check_eq(tag, (mq.size() == 0 && bfm_q.size() == 0), 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic seen;
    int   grants;
    set_default_map();
    rst_ni = 1'b0; err_cnt_m = 16'd0;
    m_req = 0; m_we = 0; m_clr = 0; m_acc = 0; m_addr = 0; m_wdata = 0; m_be = 4'hF;
    gnt_pct = 100; spur_pct = 0; dmin = 1; dmax = 1; hold = 0; use_fixed = 0; fixed_rdata = 0;
    step();
    check_eq("rst_outstanding", s_outst, 4'd0);
    check_eq("rst_rvalid", s_rvalid, 1'b0);
    step();
    #1 rst_ni = 1'b1;

    // default map decode, slave response two cycles after grant
    dmin = 2; dmax = 2; use_fixed = 1; fixed_rdata = 32'h12345678;
    m_req = 1; m_addr = 32'h1902_0004;
    step();
    check_eq("dec_slv3", s_slv_req, 5'b01000);
    m_req = 0; seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (s_rvalid) begin
        seen = 1;
        check_eq("dec_rdata", s_rdata, 32'h12345678);
        check_eq("dec_err", s_err, 1'b0);
        check_eq("dec_outst1", s_outst, 4'd1);
      end
    end
    check_eq("dec_rvalid_seen", seen, 1'b1);
    step();
    check_eq("dec_outst0", s_outst, 4'd0);
    use_fixed = 0;

    // unmapped address: self-grant, error response next cycle, then 3 back-to-back
    m_req = 1; m_addr = 32'h3000_0000;
    step();
    check_eq("unm_gnt", s_gnt, 1'b1);
    m_req = 0;
    step();
    check_eq("unm_rvalid", s_rvalid, 1'b1);
    check_eq("unm_err", s_err, 1'b1);
    check_eq("unm_rdata", s_rdata, ERRD);
    check_eq("unm_cnt1", s_errcnt, 16'd1);
    for (int i = 0; i < 4; i++) begin
      m_req = (i < 3);
      step();
      if (i > 0) check_eq("unm_b2b_rvalid", s_rvalid, 1'b1);
    end
    check_eq("unm_cnt4", s_errcnt, 16'd4);
    drain("drain_unm");

    // ordering stall: RAM0 slow, then RAM1 must wait until the cycle after RAM0 responds
    dmin = 5; dmax = 5;
    m_req = 1; m_addr = 32'h1900_0010;
    step();
    m_addr = 32'h1A00_0020; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (s_rvalid) begin
        seen = 1;
        check_eq("ord_gnt_in_rsp", s_gnt, 1'b0);
        step();
        check_eq("ord_gnt_after", s_gnt, 1'b1);
      end else begin
        check_eq("ord_stall", s_gnt, 1'b0);
      end
    end
    check_eq("ord_rsp_seen", seen, 1'b1);
    drain("drain_ord");

    // depth limit: responses held, five pipelined requests to RAM0
    dmin = 1; dmax = 1; hold = 1; grants = 0;
    m_req = 1; m_addr = 32'h1900_0040;
    for (int i = 0; i < 6; i++) begin
      step();
      if (m_acc) grants++;
      check_eq("depth_le_max", (s_outst <= 4'd4), 1'b1);
    end
    check_eq("depth_grants", grants, 4);
    hold = 0; seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (s_rvalid) begin
        seen = 1;
        check_eq("depth_gnt_in_rsp", s_gnt, 1'b0);
        step();
        check_eq("depth_gnt_after", s_gnt, 1'b1);
      end
    end
    check_eq("depth_rsp_seen", seen, 1'b1);
    drain("drain_depth");

    // overlapping rules and an out-of-range slave index
    m_req = 1; m_addr = 32'h1902_8000;
    step();
    check_eq("overlap_sel", s_slv_req, 5'b10000);
    drain("drain_ovl");
    map_idx[2] = 7;
    m_req = 1; m_addr = 32'h1A00_0010;
    step();
    check_eq("badidx_gnt", s_gnt, 1'b1);
    check_eq("badidx_noreq", s_slv_req, 5'b00000);
    m_req = 0;
    step();
    check_eq("badidx_err", s_err, 1'b1);
    drain("drain_bad");
    map_idx[2] = 2;

    // saturation and clear priority
    m_req = 1; m_addr = 32'h3000_0000;
    repeat (65535) step();
    m_req = 0;
    step();
    check_eq("sat_full", s_errcnt, 16'hFFFF);
    m_req = 1;
    step();
    m_req = 0;
    step();
    check_eq("sat_hold", s_errcnt, 16'hFFFF);
    m_req = 1; m_clr = 1;
    step();
    m_req = 0; m_clr = 0;
    step();
    check_eq("clr_prio", s_errcnt, 16'd0);
    drain("drain_sat");

    // reset with two outstanding, late slave responses must be masked
    dmin = 8; dmax = 8;
    m_req = 1; m_addr = 32'h1900_0100;
    step();
    step();
    m_req = 0;
    step();
    check_eq("rst_two_outst", s_outst, 4'd2);
    #1 rst_ni = 1'b0;
    mq.delete();
    err_cnt_m = 16'd0;
    step();
    step();
    #1 rst_ni = 1'b1;
    for (int i = 0; i < 20 && bfm_q.size() > 0; i++) begin
      step();
      check_eq("late_rsp_masked", s_rvalid, 1'b0);
    end
    drain("drain_rst");

    // randomized traffic: default map, then a map with an invalid index
    for (int p = 0; p < 2; p++) begin
      if (p == 1) map_idx[2] = 7;
      for (int c = 0; c < 1500; c++) begin
        if (c % 250 == 0) begin
          gnt_pct = $urandom_range(30, 100); spur_pct = $urandom_range(0, 30);
          dmin = 1; dmax = $urandom_range(1, 6);
        end
        if (!m_req || m_acc) begin
          m_req = ($urandom_range(0, 99) < 60);
          m_addr = rand_addr(); m_wdata = $urandom; m_we = $urandom_range(0, 1);
          m_be = 4'($urandom_range(0, 15));
        end
        m_clr = ($urandom_range(0, 49) == 0);
        step();
      end
      drain("drain_rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
